// File: rtl/noise_sample_hold_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | noise_sample_hold_if
// | Rate/control inputs and held-sample outputs of the noise sample-and-hold.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface noise_sample_hold_if #(
   parameter int OUTPUT_BITS = 12,
   parameter int FREQ_BITS   = 16
);
   logic [FREQ_BITS-1:0]   freq;
   logic                   test;
   logic [OUTPUT_BITS-1:0] noise_in;
   logic [OUTPUT_BITS-1:0] dout;
   logic                   sample_stb;

   modport master (
      output freq,
      output test,
      output noise_in,
      input  dout,
      input  sample_stb
   );

   modport slave (
      input  freq,
      input  test,
      input  noise_in,
      output dout,
      output sample_stb
   );
endinterface
`default_nettype wire

// File: rtl/noise_sample_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | noise_sample_hold
// | Phase-accumulator paced sample-and-hold for the free-running noise word.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module noise_sample_hold #(
   parameter int OUTPUT_BITS = 12,
   parameter int ACC_BITS    = 24,
   parameter int FREQ_BITS   = 16,
   parameter int TAP_BIT     = 19
) (
   input  wire logic               clk,
   input  wire logic               rst,
   noise_sample_hold_if.slave      bus
);

   localparam int c_PAD_BITS = ACC_BITS - FREQ_BITS;

   logic [ACC_BITS-1:0]    r_acc;
   logic                   r_tap_d;
   logic [OUTPUT_BITS-1:0] r_dout;
   logic                   r_sample_stb;

   logic [ACC_BITS-1:0]    w_freq_ext;
   logic                   w_rise;

   assign w_freq_ext = {{c_PAD_BITS{1'b0}}, bus.freq};

   // Rise is deliberately not gated by test: a rise seen just before test
   // asserts still produces its single capture.
   assign w_rise = r_acc[TAP_BIT] & ~r_tap_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= '0;
         r_tap_d      <= 1'b0;
         r_dout       <= '0;
         r_sample_stb <= 1'b0;
      end else begin
         r_tap_d <= r_acc[TAP_BIT];
         if (bus.test) begin
            r_acc <= '0;
         end else begin
            r_acc <= r_acc + w_freq_ext;
         end
         if (w_rise) begin
            r_dout       <= bus.noise_in;
            r_sample_stb <= 1'b1;
         end else begin
            r_sample_stb <= 1'b0;
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.sample_stb = r_sample_stb;

endmodule
`default_nettype wire

// File: tb/tb_noise_sample_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_noise_sample_hold
// | Directed scenario bench for the noise sample-and-hold stage.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_noise_sample_hold;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   noise_sample_hold_if #(.OUTPUT_BITS(12), .FREQ_BITS(16)) bus ();

   noise_sample_hold #(
      .OUTPUT_BITS(12),
      .ACC_BITS   (24),
      .FREQ_BITS  (16),
      .TAP_BIT    (19)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.freq = 16'h4000; bus.test = 1'b1; bus.noise_in = 12'hFFF;
      do_reset();
      checks++;
      if (bus.dout !== 12'h000) begin errors++; $display("FAIL reset_dout actual=%h required=000", bus.dout); end
      checks++;
      if (bus.sample_stb !== 1'b0) begin errors++; $display("FAIL reset_stb actual=%b required=0", bus.sample_stb); end
      checks++;
      if (dut.r_acc !== 24'h0) begin errors++; $display("FAIL reset_acc actual=%h required=000000", dut.r_acc); end
      bus.test = 1'b0;
   endtask

   task automatic test_fixed_rate();
      logic exp_stb;
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'hA50;
      do_reset();
      for (int n = 1; n <= 170; n++) begin
         tick();
         exp_stb = (n == 33) || (n == 97) || (n == 161);
         checks++;
         if (bus.sample_stb !== exp_stb) begin
            errors++; $display("FAIL fixed_stb edge=%0d actual=%b required=%b", n, bus.sample_stb, exp_stb);
         end
         if (n == 32) begin
            checks++;
            if (dut.r_acc !== 24'h080000) begin errors++; $display("FAIL fixed_acc32 actual=%h required=080000", dut.r_acc); end
         end
         if (n == 32 || n == 33) begin
            checks++;
            if (bus.dout !== ((n == 33) ? 12'hA50 : 12'h000)) begin
               errors++; $display("FAIL fixed_dout edge=%0d actual=%h", n, bus.dout);
            end
         end
      end
   endtask

   task automatic test_noise_track();
      logic [11:0] lfsr;
      logic [11:0] exp_dout;
      logic        exp_stb;
      lfsr = 12'hACE; exp_dout = 12'h000;
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'h000;
      do_reset();
      for (int n = 1; n <= 200; n++) begin
         bus.noise_in = lfsr;
         tick();
         exp_stb = (n == 33) || (n == 97) || (n == 161);
         if (exp_stb) exp_dout = lfsr;
         lfsr = {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
         checks++;
         if (bus.dout !== exp_dout || bus.sample_stb !== exp_stb) begin
            errors++;
            $display("FAIL track edge=%0d actual dout=%h stb=%b required dout=%h stb=%b",
                     n, bus.dout, bus.sample_stb, exp_dout, exp_stb);
         end
      end
   endtask

   task automatic test_rise_before_test();
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'h3C3;
      do_reset();
      repeat (32) tick();
      bus.test = 1'b1;
      tick();
      checks++;
      if (bus.sample_stb !== 1'b1 || bus.dout !== 12'h3C3) begin
         errors++; $display("FAIL rise_before_test actual dout=%h stb=%b required dout=3c3 stb=1", bus.dout, bus.sample_stb);
      end
      bus.test = 1'b0;
   endtask

   task automatic test_test_pulse();
      logic        exp_stb;
      logic [11:0] exp_dout;
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'hA50;
      do_reset();
      repeat (39) tick();
      bus.noise_in = 12'h123;
      bus.test = 1'b1;
      for (int n = 40; n <= 60; n++) begin
         tick();
         checks++;
         if (dut.r_acc !== 24'h0 || bus.sample_stb !== 1'b0 || bus.dout !== 12'hA50) begin
            errors++;
            $display("FAIL test_hold edge=%0d actual acc=%h stb=%b dout=%h required acc=000000 stb=0 dout=a50",
                     n, dut.r_acc, bus.sample_stb, bus.dout);
         end
      end
      bus.test = 1'b0;
      for (int m = 1; m <= 40; m++) begin
         tick();
         exp_stb  = (m == 33);
         exp_dout = (m >= 33) ? 12'h123 : 12'hA50;
         checks++;
         if (bus.sample_stb !== exp_stb || bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL test_release edge=%0d actual stb=%b dout=%h required stb=%b dout=%h",
                     m, bus.sample_stb, bus.dout, exp_stb, exp_dout);
         end
      end
   endtask

   task automatic test_freq_zero();
      int strobes;
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'hA50;
      do_reset();
      repeat (34) tick();
      bus.freq = 16'h0000; bus.noise_in = 12'h777;
      strobes = 0;
      repeat (2000) begin
         tick();
         if (bus.sample_stb === 1'b1) strobes++;
      end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL freq0_strobes actual=%0d required=0", strobes); end
      checks++;
      if (bus.dout !== 12'hA50) begin errors++; $display("FAIL freq0_dout actual=%h required=a50", bus.dout); end
      checks++;
      if (dut.r_acc !== 24'h088000) begin errors++; $display("FAIL freq0_acc actual=%h required=088000", dut.r_acc); end
   endtask

   task automatic test_wrap();
      int strobes;
      int last;
      bus.freq = 16'hFFFF; bus.test = 1'b0; bus.noise_in = 12'h5A5;
      do_reset();
      strobes = 0; last = 0;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (bus.sample_stb === 1'b1) begin
            strobes++;
            checks++;
            if (last == 0) begin
               if (n != 10) begin errors++; $display("FAIL wrap_first actual=%0d required=10", n); end
            end else if ((n - last) != 16 && (n - last) != 17) begin
               errors++; $display("FAIL wrap_gap edge=%0d actual=%0d required=16or17", n, n - last);
            end
            last = n;
         end
      end
      checks++;
      if (strobes != 19) begin errors++; $display("FAIL wrap_count actual=%0d required=19", strobes); end
      checks++;
      if (bus.dout !== 12'h5A5) begin errors++; $display("FAIL wrap_dout actual=%h required=5a5", bus.dout); end
   endtask

   task automatic test_reset_mid_hold();
      logic exp_stb;
      bus.freq = 16'h4000; bus.test = 1'b0; bus.noise_in = 12'hA50;
      do_reset();
      tick();
      checks++;
      if (bus.dout !== 12'h000 || bus.sample_stb !== 1'b0 || dut.r_acc !== 24'h004000) begin
         errors++;
         $display("FAIL mid_reset actual dout=%h stb=%b acc=%h required dout=000 stb=0 acc=004000",
                  bus.dout, bus.sample_stb, dut.r_acc);
      end
      for (int n = 2; n <= 40; n++) begin
         tick();
         exp_stb = (n == 33);
         checks++;
         if (bus.sample_stb !== exp_stb || bus.dout !== ((n >= 33) ? 12'hA50 : 12'h000)) begin
            errors++;
            $display("FAIL mid_replay edge=%0d actual stb=%b dout=%h required stb=%b", n, bus.sample_stb, bus.dout, exp_stb);
         end
      end
   endtask

   task automatic test_reset_dout_nonzero();
      // Precondition: dout holds a nonzero word from the previous scenario.
      rst = 1'b1;
      tick();
      checks++;
      if (bus.dout !== 12'h000 || bus.sample_stb !== 1'b0 || dut.r_acc !== 24'h0) begin
         errors++;
         $display("FAIL reset_hold actual dout=%h stb=%b acc=%h required 000/0/000000", bus.dout, bus.sample_stb, dut.r_acc);
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.freq = 16'h0; bus.test = 1'b0; bus.noise_in = 12'h0;
      test_reset();
      test_fixed_rate();
      test_noise_track();
      test_rise_before_test();
      test_test_pulse();
      test_freq_zero();
      test_wrap();
      test_reset_dout_nonzero();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/noise_sample_hold.md
# noise_sample_hold

Rate-controlled sample-and-hold stage directly downstream of `tone_generator_noise`. The noise LFSR free-runs on every `clk`. This block runs a SID-style 24-bit phase accumulator from a 16-bit frequency word and captures the 12-bit noise word on each rising edge of accumulator bit 19. It holds that word until the next capture, so noise pitch tracks `freq` as on the 6581. Output feeds the voice waveform mux.

## Interface
- `OUTPUT_BITS`, 12: width of `noise_in` and `dout`.
- `ACC_BITS`, 24: phase accumulator width.
- `FREQ_BITS`, 16: frequency word width; must be < `TAP_BIT`.
- `TAP_BIT`, 19: accumulator bit whose rising edge triggers a capture.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `freq`, in, `FREQ_BITS`: phase increment, zero-extended to `ACC_BITS`; sampled every cycle.
- `test`, in, 1: SID test bit. While high, the accumulator is forced to 0 and no captures occur.
- `noise_in`, in, `OUTPUT_BITS`: noise word from `tone_generator_noise.dout`.
- `dout`, out, `OUTPUT_BITS`: held noise sample (registered).
- `sample_stb`, out, 1: one-cycle pulse, high in the cycle in which `dout` shows a freshly captured word.

## Operation
- State: `acc[ACC_BITS-1:0]`, `tap_d` (registered copy of `acc[TAP_BIT]`), `dout`, `sample_stb`.
- Reset (`rst`=1 at an edge): `acc`=0, `tap_d`=0, `dout`=0, `sample_stb`=0. Reset overrides `test` and all other inputs, including mid-operation.
- Accumulator, each edge with `rst`=0:
  - If `test`=1: `acc` <= 0.
  - Otherwise: `acc` <= (`acc` + `freq`) mod 2^`ACC_BITS`. Wrap-around is silent, with no carry output.
- `tap_d` <= `acc[TAP_BIT]` every non-reset edge, including while `test` is high.
- Capture condition `rise` = `acc[TAP_BIT]` & ~`tap_d`, evaluated combinationally from current registers.
- On an edge with `rise`=1 and `rst`=0: `dout` <= `noise_in` as sampled at that same edge, and `sample_stb` <= 1.
- On any other non-reset edge: `dout` holds and `sample_stb` <= 0.
- `rise` is not gated by `test`. A rise registered in the cycle before `test` asserts still captures once.
- `test` held high:
  - `acc` stays 0, so no further rises; `dout` holds its last value indefinitely.
  - On release, counting restarts from 0.
- `freq`=0: `acc` is frozen, no captures, `dout` holds.
- A change to `freq` takes effect at the next add; there is no phase reset.
- Two rising edges of `acc[TAP_BIT]` are at least 2^(`TAP_BIT`+1)/(2^`FREQ_BITS`−1) > 2 cycles apart. No rise can be missed or merged.

## Timing
- Nominal capture period: 2^(`TAP_BIT`+1)/`freq` cycles (64 cycles for `freq`=0x4000).
- Latency chain:
  - Edge k: `acc[TAP_BIT]` goes 0→1.
  - Edge k+1: capture; `dout` and `sample_stb` change.
  - `sample_stb` is high exactly for the cycle between edges k+1 and k+2.
- `dout` changes only at edges where `sample_stb` becomes 1, or at reset.
- `sample_stb` is never high for two consecutive cycles.

## Test plan
- Reset then `freq`=0x4000, `test`=0, `noise_in`=0xA50:
  - `acc`=0x80000 after the 32nd post-reset edge.
  - `dout`=0xA50 and `sample_stb`=1 after the 33rd edge.
  - Next strobes after edges 97 and 161; `sample_stb`=0 elsewhere.
- `noise_in` changes every cycle (drive the real `tone_generator_noise`), `freq`=0x4000: each `dout` equals `noise_in` at the capture edge and holds unchanged for 63 cycles.
- `test` pulse:
  - Assert `test` at edge 40 (after the first capture): `acc` reads 0 and no strobes for the duration; `dout` holds the first captured value.
  - Deassert: next strobe exactly 33 edges after the first edge with `test`=0.
- `freq`=0: 2000 cycles with no strobe and `dout` held.
- `freq`=0xFFFF wrap: run past `acc` wrap (≥257 cycles). Strobes occur on every bit-19 rise, spaced 16 or 17 cycles apart, with no missed rise across the wrap.
- Reset mid-hold: assert `rst` for 1 cycle with `dout`≠0. Next cycle `dout`=0, `sample_stb`=0, `acc`=0, and the sequence replays scenario 1 timing.
